// File: rtl/iram_pkg.sv
// Shared types and constants for the Raspberry Pi to instruction-RAM loader.
package iram_pkg;

    localparam int IRAM_ADDR_W = 8;
    localparam int IRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic PHASE_LOW  = 1'b0;
    localparam logic PHASE_HIGH = 1'b1;

    // Instruction words are sent low byte first, stored as {high, low}.
    function automatic logic [IRAM_DATA_W-1:0] pack_word(input logic [7:0] high_byte,
                                                        input logic [7:0] low_byte);
        return {high_byte, low_byte};
    endfunction

endpackage

// File: rtl/pi_bus_sync.sv
// Multi-flop synchronizer for the Pi control lines plus a strobe rising-edge pulse.
module pi_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_async,
    input  logic wr_async,
    input  logic ai_async,
    output logic stb,
    output logic wr,
    output logic ai,
    output logic stb_rise
);

    logic [SYNC_STAGES-1:0] stb_pipe_r;
    logic [SYNC_STAGES-1:0] wr_pipe_r;
    logic [SYNC_STAGES-1:0] ai_pipe_r;
    logic                   stb_prev_r;

    // Shift the asynchronous control lines through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_pipe_r <= '0;
            wr_pipe_r  <= '0;
            ai_pipe_r  <= '0;
            stb_prev_r <= 1'b0;
        end else begin
            stb_pipe_r[0] <= stb_async;
            wr_pipe_r[0]  <= wr_async;
            ai_pipe_r[0]  <= ai_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stb_pipe_r[i] <= stb_pipe_r[i-1];
                wr_pipe_r[i]  <= wr_pipe_r[i-1];
                ai_pipe_r[i]  <= ai_pipe_r[i-1];
            end
            stb_prev_r <= stb_pipe_r[SYNC_STAGES-1];
        end
    end

    assign stb      = stb_pipe_r[SYNC_STAGES-1];
    assign wr       = wr_pipe_r[SYNC_STAGES-1];
    assign ai       = ai_pipe_r[SYNC_STAGES-1];
    // The edge detector runs even when the loader is inert, so a strobe that is
    // already high when loading is enabled never produces a spurious edge.
    assign stb_rise = stb & ~stb_prev_r;

endmodule

// File: rtl/pi_iram_loader.sv
// Assembles Pi GPIO bytes into 16-bit instruction words and writes them to IRAM.
module pi_iram_loader
    import iram_pkg::*;
#(
    parameter int ADDR_W      = IRAM_ADDR_W,
    parameter int DATA_W      = IRAM_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              gclk,
    input  logic              rst_n,
    input  logic              com_flag,
    input  logic              pi_stb,
    input  logic              pi_wr,
    input  logic              pi_ai,
    input  logic [7:0]        pi_data,
    output logic              pi_ack,
    output logic              iram_wea,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [DATA_W-1:0] iram_din,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic stb_s;
    logic wr_s;
    logic ai_s;
    logic stb_rise_s;

    state_t            state_r;
    logic              phase_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        low_r;
    logic              ack_r;
    logic              wea_r;
    logic [ADDR_W-1:0] iram_addr_r;
    logic [DATA_W-1:0] din_r;
    logic [ADDR_W:0]   words_r;

    pi_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (gclk),
        .rst_n     (rst_n),
        .stb_async (pi_stb),
        .wr_async  (pi_wr),
        .ai_async  (pi_ai),
        .stb       (stb_s),
        .wr        (wr_s),
        .ai        (ai_s),
        .stb_rise  (stb_rise_s)
    );

    // Byte-assembly FSM: capture, single-cycle write, then hold ack until strobe drops.
    always_ff @(posedge gclk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            phase_r     <= PHASE_LOW;
            addr_r      <= '0;
            low_r       <= 8'h00;
            ack_r       <= 1'b0;
            wea_r       <= 1'b0;
            iram_addr_r <= '0;
            din_r       <= '0;
            words_r     <= '0;
        end else if (!com_flag) begin
            state_r <= S_IDLE;
            phase_r <= PHASE_LOW;
            ack_r   <= 1'b0;
            wea_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ack_r <= 1'b0;
                    wea_r <= 1'b0;
                    if (stb_rise_s) begin
                        if (!wr_s) begin
                            ack_r   <= 1'b1;
                            state_r <= S_ACK;
                        end else if (ai_s) begin
                            addr_r  <= pi_data;
                            phase_r <= PHASE_LOW;
                            ack_r   <= 1'b1;
                            state_r <= S_ACK;
                        end else if (phase_r == PHASE_LOW) begin
                            low_r   <= pi_data;
                            phase_r <= PHASE_HIGH;
                            ack_r   <= 1'b1;
                            state_r <= S_ACK;
                        end else begin
                            iram_addr_r <= addr_r;
                            din_r       <= pack_word(pi_data, low_r);
                            wea_r       <= 1'b1;
                            phase_r     <= PHASE_LOW;
                            state_r     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wea_r  <= 1'b0;
                    addr_r <= addr_r + ADDR_W'(1);
                    if (words_r != WORDS_MAX) begin
                        words_r <= words_r + (ADDR_W+1)'(1);
                    end
                    ack_r   <= 1'b1;
                    state_r <= S_ACK;
                end
                S_ACK: begin
                    wea_r <= 1'b0;
                    if (!stb_s) begin
                        ack_r   <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    ack_r   <= 1'b0;
                    wea_r   <= 1'b0;
                end
            endcase
        end
    end

    // Gating with com_flag kills a write whose cycle coincides with loading being disabled.
    assign iram_wea      = wea_r & com_flag;
    assign pi_ack        = ack_r;
    assign iram_addr     = iram_addr_r;
    assign iram_din      = din_r;
    assign words_written = words_r;

endmodule

// File: tb/tb_pi_iram_loader.sv
// Self-checking bench: directed Pi transactions plus randomized streaming vs. a transaction-level model.
module tb_pi_iram_loader;

    localparam int SYNC = 2;

    logic        gclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        com_flag = 1'b0;
    logic        pi_stb = 1'b0;
    logic        pi_wr = 1'b0;
    logic        pi_ai = 1'b0;
    logic [7:0]  pi_data = 8'h00;
    logic        pi_ack;
    logic        iram_wea;
    logic [7:0]  iram_addr;
    logic [15:0] iram_din;
    logic [8:0]  words_written;

    int checks = 0;
    int failures = 0;

    // Transaction-level model of the loader
    logic [7:0]  addr_m = 8'h00;
    logic [7:0]  low_m = 8'h00;
    logic        phase_m = 1'b0;
    int          cnt_m = 0;
    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_din_q[$];

    int          wea_cnt = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [15:0] last_din = 16'h0000;

    pi_iram_loader #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .SYNC_STAGES (SYNC)
    ) dut (
        .gclk          (gclk),
        .rst_n         (rst_n),
        .com_flag      (com_flag),
        .pi_stb        (pi_stb),
        .pi_wr         (pi_wr),
        .pi_ai         (pi_ai),
        .pi_data       (pi_data),
        .pi_ack        (pi_ack),
        .iram_wea      (iram_wea),
        .iram_addr     (iram_addr),
        .iram_din      (iram_din),
        .words_written (words_written)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Every write pulse must match the next expected write from the model.
    always @(negedge gclk) begin
        if (iram_wea === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=0x%0h din=0x%0h required no write",
                         iram_addr, iram_din);
            end else begin
                chk("write_addr", 32'(iram_addr), 32'(exp_addr_q.pop_front()));
                chk("write_din", 32'(iram_din), 32'(exp_din_q.pop_front()));
            end
            wea_cnt++;
            last_addr = iram_addr;
            last_din  = iram_din;
        end
        if (com_flag == 1'b0) begin
            chk("wea_while_inert", 32'(iram_wea), 32'd0);
        end
    end

    task automatic model_reset();
        addr_m  = 8'h00;
        low_m   = 8'h00;
        phase_m = 1'b0;
        cnt_m   = 0;
        exp_addr_q.delete();
        exp_din_q.delete();
    endtask

    task automatic do_reset();
        @(negedge gclk);
        rst_n = 1'b0;
        pi_stb = 1'b0;
        repeat (3) @(negedge gclk);
        chk("rst_ack", 32'(pi_ack), 32'd0);
        chk("rst_wea", 32'(iram_wea), 32'd0);
        chk("rst_addr", 32'(iram_addr), 32'd0);
        chk("rst_din", 32'(iram_din), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        model_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge gclk);
    endtask

    // One complete four-phase byte transfer; the model is updated before the strobe rises.
    task automatic xfer(input logic wr, input logic ai, input logic [7:0] d, input int hold);
        int   n;
        int   lat;
        logic ok;
        lat = SYNC + 1;
        if (wr) begin
            if (ai) begin
                addr_m  = d;
                phase_m = 1'b0;
            end else if (!phase_m) begin
                low_m   = d;
                phase_m = 1'b1;
            end else begin
                lat = SYNC + 2;
                exp_addr_q.push_back(addr_m);
                exp_din_q.push_back({d, low_m});
                addr_m  = addr_m + 8'd1;
                phase_m = 1'b0;
                if (cnt_m < 256) cnt_m++;
            end
        end
        @(negedge gclk);
        pi_wr   = wr;
        pi_ai   = ai;
        pi_data = d;
        pi_stb  = 1'b1;
        n = 0;
        do begin
            @(negedge gclk);
            n++;
        end while (!pi_ack && n < 16);
        chk("ack_latency", 32'(n), 32'(lat));
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge gclk);
            if (!pi_ack) ok = 1'b0;
        end
        if (hold > 0) chk("ack_held", 32'(ok), 32'd1);
        pi_stb = 1'b0;
        n = 0;
        do begin
            @(negedge gclk);
            n++;
        end while (pi_ack && n < 16);
        chk("ack_release", 32'(n), 32'(SYNC + 1));
        chk("words_written", 32'(words_written), 32'(cnt_m));
        pi_data = 8'($urandom);
    endtask

    initial begin
        int wc;
        logic ok;

        // Reset state
        do_reset();

        // 1: single word at 0x10
        com_flag = 1'b1;
        repeat (2) @(negedge gclk);
        xfer(1'b1, 1'b1, 8'h10, 0);
        xfer(1'b1, 1'b0, 8'h34, 0);
        xfer(1'b1, 1'b0, 8'h12, 0);
        chk("t1_addr", 32'(last_addr), 32'h10);
        chk("t1_din", 32'(last_din), 32'h1234);
        chk("t1_words", 32'(words_written), 32'd1);
        chk("t1_count", 32'(wea_cnt), 32'd1);

        // 2: auto-increment across the address wrap
        xfer(1'b1, 1'b1, 8'hFE, 0);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'hAA : ((i == 1) ? 8'hBB : 8'hCC);
            xfer(1'b1, 1'b0, b, 0);
            xfer(1'b1, 1'b0, b, 0);
        end
        chk("t2_wrap_addr", 32'(last_addr), 32'h00);
        chk("t2_din", 32'(last_din), 32'hCCCC);
        chk("t2_words", 32'(words_written), 32'd4);

        // 3: address byte mid-word discards pending low byte
        xfer(1'b1, 1'b1, 8'h20, 0);
        xfer(1'b1, 1'b0, 8'h55, 0);
        xfer(1'b1, 1'b1, 8'h30, 0);
        xfer(1'b1, 1'b0, 8'h01, 0);
        xfer(1'b1, 1'b0, 8'h02, 0);
        chk("t3_addr", 32'(last_addr), 32'h30);
        chk("t3_din", 32'(last_din), 32'h0201);
        chk("t3_count", 32'(wea_cnt), 32'd5);

        // 4: long strobe hold gives one capture only
        xfer(1'b1, 1'b1, 8'h70, 20);
        xfer(1'b1, 1'b0, 8'h11, 20);
        wc = wea_cnt;
        xfer(1'b1, 1'b0, 8'h22, 20);
        chk("t4_single_write", 32'(wea_cnt - wc), 32'd1);
        chk("t4_din", 32'(last_din), 32'h2211);

        // 5: com_flag drop resets byte phase, ignores strobes
        xfer(1'b1, 1'b1, 8'h60, 0);
        xfer(1'b1, 1'b0, 8'h99, 0);
        @(negedge gclk);
        com_flag = 1'b0;
        phase_m  = 1'b0;
        @(negedge gclk);
        ok = 1'b1;
        pi_wr = 1'b1;
        pi_ai = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pi_stb = 1'b1;
            repeat (4) begin @(negedge gclk); if (pi_ack) ok = 1'b0; end
            pi_stb = 1'b0;
            repeat (4) begin @(negedge gclk); if (pi_ack) ok = 1'b0; end
        end
        pi_stb = 1'b1;
        repeat (4) @(negedge gclk);
        com_flag = 1'b1;
        repeat (8) begin @(negedge gclk); if (pi_ack) ok = 1'b0; end
        pi_stb = 1'b0;
        repeat (4) begin @(negedge gclk); if (pi_ack) ok = 1'b0; end
        chk("t5_no_ack_inert", 32'(ok), 32'd1);
        wc = wea_cnt;
        xfer(1'b1, 1'b0, 8'h78, 0);
        xfer(1'b1, 1'b0, 8'h56, 0);
        chk("t5_addr", 32'(last_addr), 32'h60);
        chk("t5_din", 32'(last_din), 32'h5678);
        chk("t5_count", 32'(wea_cnt - wc), 32'd1);

        // Randomized streaming, long enough to saturate words_written
        for (int i = 0; i < 700; i++) begin
            int r;
            int h;
            r = int'($urandom_range(0, 99));
            h = (int'($urandom_range(0, 9)) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (r < 8) xfer(1'b1, 1'b1, 8'($urandom), h);
            else if (r < 12) xfer(1'b0, 1'($urandom), 8'($urandom), h);
            else xfer(1'b1, 1'b0, 8'($urandom), h);
        end
        chk("rand_saturated", 32'(words_written), 32'd256);

        // 6: read request is acked without a write
        wc = wea_cnt;
        xfer(1'b0, 1'b0, 8'hEE, 0);
        chk("t6_read_no_write", 32'(wea_cnt - wc), 32'd0);

        // 6: reset mid-word loses the partial word
        xfer(1'b1, 1'b1, 8'h40, 0);
        xfer(1'b1, 1'b0, 8'h11, 0);
        wc = wea_cnt;
        do_reset();
        chk("t6_no_write_on_reset", 32'(wea_cnt - wc), 32'd0);
        com_flag = 1'b1;
        repeat (2) @(negedge gclk);
        xfer(1'b1, 1'b0, 8'h22, 0);
        xfer(1'b1, 1'b0, 8'h33, 0);
        chk("t6_post_reset_addr", 32'(last_addr), 32'h00);
        chk("t6_post_reset_din", 32'(last_din), 32'h3322);
        chk("t6_post_reset_words", 32'(words_written), 32'd1);

        repeat (4) @(negedge gclk);
        chk("queue_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
